// File: rtl/rvfpm_xif_pkg.sv
// Shared types for the XIF commit scheduler.
//   id_state_e   : life-cycle state of one instruction ID
//   done_entry_t : one datapath completion as buffered in the result FIFO
package rvfpm_xif_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;
  localparam int XLEN        = 32;
  localparam int X_WE_WIDTH  = X_RFW_WIDTH / XLEN;
  localparam int NUM_IDS     = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {
    ID_FREE      = 2'd0,
    ID_ISSUED    = 2'd1,
    ID_COMMITTED = 2'd2,
    ID_KILLED    = 2'd3
  } id_state_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic [X_WE_WIDTH-1:0]  we;
    logic                   exc;
    logic [5:0]             exccode;
  } done_entry_t;

endpackage

// File: rtl/xif_commit_scheduler_if.sv
// Bundle of the issue / commit / kill / completion / result / status signals
// between the core side (master) and the commit scheduler (slave).
interface xif_commit_scheduler_if;
  import rvfpm_xif_pkg::*;

  logic                   issue_valid;
  logic [X_ID_WIDTH-1:0]  issue_id;
  logic                   issue_accept;
  logic                   issue_ready;

  logic                   commit_valid;
  logic [X_ID_WIDTH-1:0]  commit_id;
  logic                   commit_kill;
  logic                   kill_valid;
  logic [X_ID_WIDTH-1:0]  kill_id;

  logic                   done_valid;
  logic                   done_ready;
  logic [X_ID_WIDTH-1:0]  done_id;
  logic [X_RFW_WIDTH-1:0] done_data;
  logic [4:0]             done_rd;
  logic [X_WE_WIDTH-1:0]  done_we;
  logic                   done_exc;
  logic [5:0]             done_exccode;

  logic                   result_valid;
  logic                   result_ready;
  logic [X_ID_WIDTH-1:0]  result_id;
  logic [X_RFW_WIDTH-1:0] result_data;
  logic [4:0]             result_rd;
  logic [X_WE_WIDTH-1:0]  result_we;
  logic                   result_exc;
  logic [5:0]             result_exccode;

  logic [X_ID_WIDTH:0]    outstanding;
  logic                   protocol_err;

  modport master (
    output issue_valid, issue_id, issue_accept, commit_valid, commit_id, commit_kill,
           done_valid, done_id, done_data, done_rd, done_we, done_exc, done_exccode,
           result_ready,
    input  issue_ready, kill_valid, kill_id, done_ready, result_valid, result_id,
           result_data, result_rd, result_we, result_exc, result_exccode,
           outstanding, protocol_err
  );

  modport slave (
    input  issue_valid, issue_id, issue_accept, commit_valid, commit_id, commit_kill,
           done_valid, done_id, done_data, done_rd, done_we, done_exc, done_exccode,
           result_ready,
    output issue_ready, kill_valid, kill_id, done_ready, result_valid, result_id,
           result_data, result_rd, result_we, result_exc, result_exccode,
           outstanding, protocol_err
  );

endinterface

// File: rtl/xif_result_fifo.sv
// Synchronous FIFO of generic element type.
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   i_push/i_data: write request and element (ignored when full)
//   i_pop        : read request (ignored when empty)
//   o_full/o_empty/o_head : status and the element at the read pointer
module xif_result_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  T            r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/xif_commit_scheduler.sv
// XIF coprocessor commit scheduler: tracks each ID through issue, commit or
// kill, buffers datapath completions in order, presents committed results on
// the XIF result channel and silently drops killed ones.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : issue/commit/kill/done/result channels plus outstanding
//                  count and sticky protocol_err
module xif_commit_scheduler
  import rvfpm_xif_pkg::*;
#(
  parameter int RES_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  xif_commit_scheduler_if.slave  bus
);

  localparam logic [X_ID_WIDTH:0] OUT_MAX = (X_ID_WIDTH+1)'(NUM_IDS);

  id_state_e           r_state [NUM_IDS];
  logic                r_kill_valid;
  logic [X_ID_WIDTH-1:0] r_kill_id;
  logic [X_ID_WIDTH:0] r_outstanding;
  logic                r_protocol_err;

  done_entry_t         w_done_entry;
  done_entry_t         w_head;
  logic                w_full;
  logic                w_empty;
  id_state_e           w_head_state;
  logic                w_issue_fire;
  logic                w_commit_ok;
  logic                w_commit_bad;
  logic                w_done_hs;
  logic                w_done_free;
  logic                w_push;
  logic                w_result_valid;
  logic                w_pop;

  // issue_ready looks at registered state, so an ID freed this cycle is issuable next cycle.
  assign bus.issue_ready = (r_state[bus.issue_id] == ID_FREE);
  assign w_issue_fire    = bus.issue_valid && bus.issue_ready && bus.issue_accept;

  // A commit for an ID being issued in the same cycle still sees FREE and is rejected.
  assign w_commit_ok  = bus.commit_valid && (r_state[bus.commit_id] == ID_ISSUED);
  assign w_commit_bad = bus.commit_valid && !w_commit_ok;

  assign bus.done_ready = !w_full;
  assign w_done_hs      = bus.done_valid && !w_full;
  assign w_done_free    = w_done_hs && (r_state[bus.done_id] == ID_FREE);
  assign w_push         = w_done_hs && !w_done_free;
  assign w_done_entry   = '{id: bus.done_id, data: bus.done_data, rd: bus.done_rd,
                            we: bus.done_we, exc: bus.done_exc, exccode: bus.done_exccode};

  xif_result_fifo #(
    .T     (done_entry_t),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_done_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Strictly in-order head: committed heads are offered, killed heads are
  // discarded without a handshake, issued heads block everything behind them.
  assign w_head_state   = r_state[w_head.id];
  assign w_result_valid = !w_empty && (w_head_state == ID_COMMITTED);
  assign w_pop          = (w_result_valid && bus.result_ready) ||
                          (!w_empty && (w_head_state == ID_KILLED));

  // Payload is forced to zero while not valid so idle outputs never show stale FIFO data.
  assign bus.result_valid   = w_result_valid;
  assign bus.result_id      = w_result_valid ? w_head.id      : '0;
  assign bus.result_data    = w_result_valid ? w_head.data    : '0;
  assign bus.result_rd      = w_result_valid ? w_head.rd      : '0;
  assign bus.result_we      = w_result_valid ? w_head.we      : '0;
  assign bus.result_exc     = w_result_valid ? w_head.exc     : '0;
  assign bus.result_exccode = w_result_valid ? w_head.exccode : '0;

  assign bus.kill_valid   = r_kill_valid;
  assign bus.kill_id      = r_kill_id;
  assign bus.outstanding  = r_outstanding;
  assign bus.protocol_err = r_protocol_err;

  // The three updates target distinct IDs: pop needs COMMITTED/KILLED,
  // issue needs FREE, commit needs ISSUED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IDS; i++) r_state[i] <= ID_FREE;
    end else begin
      if (w_pop)        r_state[w_head.id]    <= ID_FREE;
      if (w_issue_fire) r_state[bus.issue_id] <= ID_ISSUED;
      if (w_commit_ok)  r_state[bus.commit_id] <= bus.commit_kill ? ID_KILLED : ID_COMMITTED;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kill_valid   <= 1'b0;
      r_kill_id      <= '0;
      r_outstanding  <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_kill_valid <= w_commit_ok && bus.commit_kill;
      if (w_commit_ok && bus.commit_kill) r_kill_id <= bus.commit_id;
      if (w_commit_bad || w_done_free) r_protocol_err <= 1'b1;
      case ({w_issue_fire, w_pop})
        2'b10:   if (r_outstanding != OUT_MAX) r_outstanding <= r_outstanding + 1'b1;
        2'b01:   if (r_outstanding != '0)      r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_commit_scheduler.sv
module tb_xif_commit_scheduler;
  import rvfpm_xif_pkg::*;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  xif_commit_scheduler_if u_if ();

  xif_commit_scheduler #(.RES_DEPTH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_issue(input logic [3:0] id);
    u_if.issue_valid  = 1'b1;
    u_if.issue_id     = id;
    u_if.issue_accept = 1'b1;
    tick();
    u_if.issue_valid  = 1'b0;
    u_if.issue_accept = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    u_if.commit_valid = 1'b1;
    u_if.commit_id    = id;
    u_if.commit_kill  = kill;
    tick();
    u_if.commit_valid = 1'b0;
    u_if.commit_kill  = 1'b0;
  endtask

  task automatic do_done(input logic [3:0] id, input logic [31:0] data);
    u_if.done_valid = 1'b1;
    u_if.done_id    = id;
    u_if.done_data  = data;
    tick();
    u_if.done_valid = 1'b0;
  endtask

  logic [3:0]  exp_ids  [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
  logic [31:0] exp_data [4] = '{32'h90, 32'hA0, 32'hB0, 32'hC0};

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    u_if.issue_valid = 1'b0;  u_if.issue_id = '0;  u_if.issue_accept = 1'b0;
    u_if.commit_valid = 1'b0; u_if.commit_id = '0; u_if.commit_kill = 1'b0;
    u_if.done_valid = 1'b0;   u_if.done_id = '0;   u_if.done_data = '0;
    u_if.done_rd = 5'd0;      u_if.done_we = '0;   u_if.done_exc = 1'b0;
    u_if.done_exccode = 6'd0; u_if.result_ready = 1'b0;
    #1;
    chk("rst_result_valid", u_if.result_valid, 0);
    chk("rst_issue_ready", u_if.issue_ready, 1);
    chk("rst_outstanding", u_if.outstanding, 0);
    chk("rst_protocol_err", u_if.protocol_err, 0);
    chk("rst_done_ready", u_if.done_ready, 1);
    chk("rst_kill_valid", u_if.kill_valid, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Committed result with back-pressure
    do_issue(4'd3);
    chk("t2_outstanding", u_if.outstanding, 1);
    do_commit(4'd3, 1'b0);
    chk("t2_no_result_before_done", u_if.result_valid, 0);
    do_done(4'd3, 32'h3F800000);
    chk("t2_result_valid", u_if.result_valid, 1);
    chk("t2_result_id", u_if.result_id, 3);
    chk("t2_result_data", u_if.result_data, 64'h3F800000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_valid", u_if.result_valid, 1);
      chk("t2_hold_data", u_if.result_data, 64'h3F800000);
    end
    u_if.result_ready = 1'b1;
    tick();
    u_if.result_ready = 1'b0;
    chk("t2_after_pop_valid", u_if.result_valid, 0);
    chk("t2_after_pop_outstanding", u_if.outstanding, 0);
    u_if.issue_id = 4'd3;
    #1;
    chk("t2_id3_free", u_if.issue_ready, 1);

    // Kill drops a buffered completion
    do_issue(4'd1);
    do_issue(4'd2);
    do_done(4'd1, 32'h11);
    do_done(4'd2, 32'h22);
    chk("t3_head_issued_blocks", u_if.result_valid, 0);
    chk("t3_outstanding2", u_if.outstanding, 2);
    do_commit(4'd1, 1'b1);
    chk("t3_kill_valid", u_if.kill_valid, 1);
    chk("t3_kill_id", u_if.kill_id, 1);
    chk("t3_killed_not_offered", u_if.result_valid, 0);
    tick();
    chk("t3_kill_pulse_end", u_if.kill_valid, 0);
    chk("t3_outstanding1", u_if.outstanding, 1);
    chk("t3_id2_waits", u_if.result_valid, 0);
    do_commit(4'd2, 1'b0);
    chk("t3_result_valid", u_if.result_valid, 1);
    chk("t3_result_id", u_if.result_id, 2);
    chk("t3_result_data", u_if.result_data, 64'h22);
    u_if.result_ready = 1'b1;
    tick();
    u_if.result_ready = 1'b0;
    chk("t3_done_valid", u_if.result_valid, 0);
    chk("t3_done_outstanding", u_if.outstanding, 0);

    // Re-issue of an in-flight ID
    do_issue(4'd5);
    u_if.issue_id = 4'd5;
    #1;
    chk("t4_busy", u_if.issue_ready, 0);
    do_commit(4'd5, 1'b0);
    do_done(4'd5, 32'h55);
    chk("t4_result_valid", u_if.result_valid, 1);
    u_if.result_ready = 1'b1;
    u_if.issue_valid  = 1'b1;
    u_if.issue_id     = 4'd5;
    u_if.issue_accept = 1'b1;
    #1;
    chk("t4_blocked_in_pop_cycle", u_if.issue_ready, 0);
    tick();
    u_if.result_ready = 1'b0;
    chk("t4_ready_after_pop", u_if.issue_ready, 1);
    chk("t4_outstanding0", u_if.outstanding, 0);
    tick();
    u_if.issue_valid  = 1'b0;
    u_if.issue_accept = 1'b0;
    chk("t4_reissued", u_if.outstanding, 1);
    chk("t4_busy_again", u_if.issue_ready, 0);
    do_commit(4'd5, 1'b1);
    do_done(4'd5, 32'h56);
    chk("t4_killed_silent", u_if.result_valid, 0);
    tick();
    chk("t4_drained", u_if.outstanding, 0);

    // Full FIFO back-pressure and ordering
    do_issue(4'd8);  do_issue(4'd9);  do_issue(4'd10);
    do_issue(4'd11); do_issue(4'd12);
    chk("t5_outstanding5", u_if.outstanding, 5);
    do_done(4'd8, 32'h80);  do_done(4'd9, 32'h90);
    do_done(4'd10, 32'hA0); do_done(4'd11, 32'hB0);
    chk("t5_full", u_if.done_ready, 0);
    chk("t5_no_result", u_if.result_valid, 0);
    do_commit(4'd8, 1'b0);
    chk("t5_head_valid", u_if.result_valid, 1);
    chk("t5_head_id", u_if.result_id, 8);
    u_if.result_ready = 1'b1;
    u_if.done_valid   = 1'b1;
    u_if.done_id      = 4'd12;
    u_if.done_data    = 32'hC0;
    #1;
    chk("t5_no_push_while_full", u_if.done_ready, 0);
    tick();
    u_if.result_ready = 1'b0;
    chk("t5_space_after_pop", u_if.done_ready, 1);
    tick();
    u_if.done_valid = 1'b0;
    chk("t5_full_again", u_if.done_ready, 0);
    do_commit(4'd9, 1'b0);  do_commit(4'd10, 1'b0);
    do_commit(4'd11, 1'b0); do_commit(4'd12, 1'b0);
    u_if.result_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_order_valid", u_if.result_valid, 1);
      chk("t5_order_id", u_if.result_id, exp_ids[k]);
      chk("t5_order_data", u_if.result_data, exp_data[k]);
      tick();
    end
    u_if.result_ready = 1'b0;
    chk("t5_empty", u_if.result_valid, 0);
    chk("t5_outstanding0", u_if.outstanding, 0);
    chk("t5_err_clear", u_if.protocol_err, 0);

    // Protocol errors
    do_commit(4'd7, 1'b0);
    chk("t6_err_set", u_if.protocol_err, 1);
    chk("t6_no_kill", u_if.kill_valid, 0);
    tick(); tick();
    chk("t6_err_sticky", u_if.protocol_err, 1);
    do_done(4'd6, 32'h66);
    chk("t6_free_done_dropped", u_if.result_valid, 0);
    do_issue(4'd6);
    do_commit(4'd6, 1'b0);
    chk("t6_nothing_buffered", u_if.result_valid, 0);
    do_done(4'd6, 32'h67);
    chk("t6_real_result_id", u_if.result_id, 6);
    chk("t6_real_result_data", u_if.result_data, 64'h67);
    u_if.result_ready = 1'b1;
    tick();
    u_if.result_ready = 1'b0;

    // Commit in the same cycle as the issue of that ID is ignored
    u_if.commit_valid = 1'b1;
    u_if.commit_id    = 4'd4;
    do_issue(4'd4);
    u_if.commit_valid = 1'b0;
    do_done(4'd4, 32'h44);
    chk("t7_same_cycle_commit_ignored", u_if.result_valid, 0);
    do_commit(4'd4, 1'b0);
    chk("t7_late_commit_id", u_if.result_id, 4);
    u_if.result_ready = 1'b1;
    tick();
    u_if.result_ready = 1'b0;

    // Reset in the middle of a transaction
    do_issue(4'd13);
    do_commit(4'd13, 1'b0);
    do_done(4'd13, 32'hD0);
    chk("t1_pre_reset_valid", u_if.result_valid, 1);
    u_if.issue_id = 4'd13;
    reset_n = 1'b0;
    #1;
    chk("t1_result_valid", u_if.result_valid, 0);
    chk("t1_issue_ready", u_if.issue_ready, 1);
    chk("t1_outstanding", u_if.outstanding, 0);
    chk("t1_protocol_err", u_if.protocol_err, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("t1_no_result_after", u_if.result_valid, 0);
    chk("t1_done_ready", u_if.done_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
